// File: rtl/ac_pkg.sv
// Shared types and constants for the streaming Aho-Corasick matcher.
// Holds the FSM encoding, config-port select codes and the goto-entry layout.
package ac_pkg;

    localparam int DEF_STATE_W    = 8;
    localparam int DEF_CHAR_W     = 4;
    localparam int DEF_GOTO_DEPTH = 32;
    localparam int DEF_NUM_STATES = 32;
    localparam int DEF_ID_W       = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } ac_fsm_e;

    localparam logic [1:0] CFG_SEL_GOTO = 2'd0;
    localparam logic [1:0] CFG_SEL_FAIL = 2'd1;
    localparam logic [1:0] CFG_SEL_OUT  = 2'd2;
    localparam logic [1:0] CFG_SEL_RSVD = 2'd3;

    // Goto entry as packed on the config port: {cur, chr, nxt}.
    typedef struct packed {
        logic [DEF_STATE_W-1:0] cur;
        logic [DEF_CHAR_W-1:0]  chr;
        logic [DEF_STATE_W-1:0] nxt;
    } goto_entry_t;

endpackage

// File: rtl/ac_table_ram.sv
// Small table memory: one synchronous write port, one asynchronous read port.
// Addresses at or beyond DEPTH are ignored on write and read back as zero.
module ac_table_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // A full power-of-two table needs no range guard; a partial one does.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_part
            assign wr_ok = (waddr < ADDR_W'(DEPTH));
            assign rd_ok = (raddr < ADDR_W'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = rd_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/ac_stream_matcher.sv
// Streaming Aho-Corasick matcher: one character per handshake, linear goto scan
// with failure-link fallback, reporting the resolved state and pattern id.
module ac_stream_matcher
    import ac_pkg::*;
#(
    parameter int STATE_W    = DEF_STATE_W,
    parameter int CHAR_W     = DEF_CHAR_W,
    parameter int GOTO_DEPTH = DEF_GOTO_DEPTH,
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int ID_W       = DEF_ID_W,
    parameter int GA_W       = $clog2(GOTO_DEPTH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        SOFT_CLR,
    input  logic                        CHAR_VALID,
    input  logic [CHAR_W-1:0]           CHAR_IN,
    output logic                        CHAR_READY,
    input  logic [GA_W:0]               NUM_ENT,
    input  logic                        CFG_WE,
    input  logic [1:0]                  CFG_SEL,
    input  logic [GA_W-1:0]             CFG_ADDR,
    input  logic [2*STATE_W+CHAR_W-1:0] CFG_DATA,
    output logic                        OUT_VALID,
    output logic [STATE_W-1:0]          NOW_STATE,
    output logic                        MATCH,
    output logic [ID_W-1:0]             MATCH_ID,
    output logic                        ERR
);

    localparam int            GE_W     = 2*STATE_W + CHAR_W;
    localparam logic [0:0]    ST_IDLE  = IDLE;
    localparam logic [0:0]    ST_SCAN  = SCAN;

    logic [0:0]         fsm_q;
    logic [STATE_W-1:0] cur_q;
    logic [CHAR_W-1:0]  chr_q;
    logic [GA_W-1:0]    addr_q;
    logic [GA_W-1:0]    last_q;
    logic [GA_W-1:0]    last_d;
    logic [STATE_W-1:0] now_state_q;
    logic               out_valid_q;
    logic               match_q;
    logic [ID_W-1:0]    match_id_q;
    logic               err_q;

    logic               cfg_ok;
    logic [GE_W-1:0]    goto_rdata;
    logic [STATE_W-1:0] g_cur;
    logic [CHAR_W-1:0]  g_chr;
    logic [STATE_W-1:0] g_nxt;
    logic [STATE_W-1:0] fail_rdata;
    logic [ID_W-1:0]    out_rdata;
    logic [STATE_W-1:0] next_state_d;
    logic               hit;

    // Table writes only land while idle; writes during a scan are dropped.
    assign cfg_ok     = CFG_WE && (fsm_q == ST_IDLE);
    assign CHAR_READY = (fsm_q == ST_IDLE) && !CFG_WE && !SOFT_CLR;

    ac_table_ram #(
        .WIDTH  (GE_W),
        .DEPTH  (GOTO_DEPTH),
        .ADDR_W (GA_W)
    ) u_goto (
        .clk   (CLK),
        .we    (cfg_ok && (CFG_SEL == CFG_SEL_GOTO)),
        .waddr (CFG_ADDR),
        .wdata (CFG_DATA),
        .raddr (addr_q),
        .rdata (goto_rdata)
    );

    ac_table_ram #(
        .WIDTH  (STATE_W),
        .DEPTH  (NUM_STATES),
        .ADDR_W (STATE_W)
    ) u_fail (
        .clk   (CLK),
        .we    (cfg_ok && (CFG_SEL == CFG_SEL_FAIL)),
        .waddr (STATE_W'(CFG_ADDR)),
        .wdata (CFG_DATA[STATE_W-1:0]),
        .raddr (cur_q),
        .rdata (fail_rdata)
    );

    ac_table_ram #(
        .WIDTH  (ID_W),
        .DEPTH  (NUM_STATES),
        .ADDR_W (STATE_W)
    ) u_out (
        .clk   (CLK),
        .we    (cfg_ok && (CFG_SEL == CFG_SEL_OUT)),
        .waddr (STATE_W'(CFG_ADDR)),
        .wdata (CFG_DATA[ID_W-1:0]),
        .raddr (next_state_d),
        .rdata (out_rdata)
    );

    assign g_cur        = goto_rdata[GE_W-1 -: STATE_W];
    assign g_chr        = goto_rdata[STATE_W+CHAR_W-1 -: CHAR_W];
    assign g_nxt        = goto_rdata[STATE_W-1:0];
    assign hit          = (g_cur == cur_q) && (g_chr == chr_q);
    assign next_state_d = hit ? g_nxt : '0;

    // Last scanned index: zero entries behaves as one, oversize clamps to the table.
    always_comb begin
        last_d = '0;
        if (NUM_ENT == '0) begin
            last_d = '0;
        end else if (NUM_ENT > (GA_W+1)'(GOTO_DEPTH)) begin
            last_d = GA_W'(GOTO_DEPTH - 1);
        end else begin
            last_d = GA_W'(NUM_ENT - 1'b1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm_q       <= ST_IDLE;
            cur_q       <= '0;
            chr_q       <= '0;
            addr_q      <= '0;
            last_q      <= '0;
            now_state_q <= '0;
            out_valid_q <= 1'b0;
            match_q     <= 1'b0;
            match_id_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (SOFT_CLR) begin
                fsm_q       <= ST_IDLE;
                now_state_q <= '0;
                match_q     <= 1'b0;
            end else if (fsm_q == ST_IDLE) begin
                if (CHAR_VALID && CHAR_READY) begin
                    chr_q  <= CHAR_IN;
                    cur_q  <= now_state_q;
                    addr_q <= '0;
                    last_q <= last_d;
                    fsm_q  <= ST_SCAN;
                end
            end else if (hit || ((addr_q == last_q) && (cur_q == '0))) begin
                now_state_q <= next_state_d;
                match_q     <= |out_rdata;
                match_id_q  <= out_rdata;
                out_valid_q <= 1'b1;
                fsm_q       <= ST_IDLE;
            end else if (addr_q == last_q) begin
                // A failure link pointing at itself would loop forever; fall back to root.
                addr_q <= '0;
                if (fail_rdata == cur_q) begin
                    cur_q <= '0;
                    err_q <= 1'b1;
                end else begin
                    cur_q <= fail_rdata;
                end
            end else begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign NOW_STATE = now_state_q;
    assign MATCH     = match_q;
    assign MATCH_ID  = match_id_q;
    assign ERR       = err_q;

endmodule
